// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: turns host RUN/QUIT/STEP/SET_BRK commands into
// start/quit pulses for the CPU status block, with step counting and a PC breakpoint.
module cpu_run_ctrl #(
  parameter int PC_W   = 32,
  parameter int STEP_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [31:0]     cmd_arg,
  input  logic            stall,
  input  logic [PC_W-1:0] pc_if,
  output logic            cpu_start,
  output logic            quit_cmd,
  output logic            running,
  output logic            brk_hit,
  output logic            step_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_QUIT = 2'd3
  } state_t;

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_QUIT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_BRK  = 2'b11;

  state_t            state;
  logic              brk_en;
  logic [PC_W-1:0]   brk_addr;
  logic [STEP_W-1:0] cnt;

  logic              accept;
  logic              host_quit;
  logic              brk_match;
  logic              step_end;
  logic [STEP_W-1:0] step_n;

  assign cmd_ready = (state != S_QUIT);
  assign accept    = cmd_valid & cmd_ready;
  assign host_quit = accept & (cmd_op == OP_QUIT);
  assign step_n    = cmd_arg[STEP_W-1:0];

  // Compare uses the registered breakpoint, so a SET_BRK in the same cycle
  // only takes effect from the next cycle.
  assign brk_match = brk_en & ~stall & (pc_if == brk_addr);
  assign step_end  = (cnt == STEP_W'(1)) & ~stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cpu_start <= 1'b0;
      quit_cmd  <= 1'b0;
      running   <= 1'b0;
      brk_hit   <= 1'b0;
      step_done <= 1'b0;
      brk_en    <= 1'b0;
      brk_addr  <= '0;
      cnt       <= '0;
    end else begin
      cpu_start <= 1'b0;
      quit_cmd  <= 1'b0;
      step_done <= 1'b0;

      if (accept && cmd_op == OP_BRK) begin
        if (cmd_arg == 32'hFFFF_FFFF) begin
          brk_en <= 1'b0;
        end else begin
          brk_addr <= cmd_arg[PC_W-1:0];
          brk_en   <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (accept && cmd_op == OP_RUN) begin
            cpu_start <= 1'b1;
            brk_hit   <= 1'b0;
            running   <= 1'b1;
            state     <= S_RUN;
          end else if (accept && cmd_op == OP_STEP) begin
            if (step_n == '0) begin
              step_done <= 1'b1;
            end else begin
              cpu_start <= 1'b1;
              brk_hit   <= 1'b0;
              cnt       <= step_n;
              running   <= 1'b1;
              state     <= S_STEP;
            end
          end
        end

        S_RUN: begin
          if (brk_match || host_quit) begin
            quit_cmd <= 1'b1;
            running  <= 1'b0;
            state    <= S_QUIT;
            if (brk_match) brk_hit <= 1'b1;
          end
        end

        // All stop sources merge into a single quit pulse; each flag reports its own cause.
        S_STEP: begin
          if (!stall && cnt != '0) cnt <= cnt - STEP_W'(1);
          if (brk_match || host_quit || step_end) begin
            quit_cmd <= 1'b1;
            running  <= 1'b0;
            state    <= S_QUIT;
            if (brk_match) brk_hit <= 1'b1;
            if (step_end) step_done <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl; outputs are packed as
// {cpu_start, quit_cmd, running, brk_hit, step_done, cmd_ready} for comparison.
module tb_cpu_run_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        stall;
  logic [31:0] pc_if;
  logic        cpu_start;
  logic        quit_cmd;
  logic        running;
  logic        brk_hit;
  logic        step_done;

  int tests_run;
  int tests_failed;

  logic [5:0] obs;
  assign obs = {cpu_start, quit_cmd, running, brk_hit, step_done, cmd_ready};

  cpu_run_ctrl #(.PC_W(32), .STEP_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .stall     (stall),
    .pc_if     (pc_if),
    .cpu_start (cpu_start),
    .quit_cmd  (quit_cmd),
    .running   (running),
    .brk_hit   (brk_hit),
    .step_done (step_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command for exactly one edge, then drop valid.
  task automatic issue(input logic [1:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = '0; stall = 1'b1; pc_if = '0;
    tick(); tick();
    tests_run++;
    if (obs !== 6'b000001) begin tests_failed++; $display("[TB] FAIL reset_hold: got %b want %b", obs, 6'b000001); end
    rst = 1'b0;
    tick();
    tests_run++;
    if (obs !== 6'b000001) begin tests_failed++; $display("[TB] FAIL reset_release: got %b want %b", obs, 6'b000001); end
  endtask

  task automatic test_run_quit();
    issue(2'b00, 32'h0);
    tests_run++;
    if (obs !== 6'b101001) begin tests_failed++; $display("[TB] FAIL run_start: got %b want %b", obs, 6'b101001); end
    tick();
    tests_run++;
    if (obs !== 6'b001001) begin tests_failed++; $display("[TB] FAIL run_start_once: got %b want %b", obs, 6'b001001); end
    issue(2'b10, 32'h1);
    tests_run++;
    if (obs !== 6'b001001) begin tests_failed++; $display("[TB] FAIL run_ignore_step: got %b want %b", obs, 6'b001001); end
    tick();
    tests_run++;
    if (obs !== 6'b001001) begin tests_failed++; $display("[TB] FAIL run_still_running: got %b want %b", obs, 6'b001001); end
    issue(2'b01, 32'h0);
    tests_run++;
    if (obs !== 6'b010000) begin tests_failed++; $display("[TB] FAIL quit_pulse: got %b want %b", obs, 6'b010000); end
    tick();
    tests_run++;
    if (obs !== 6'b000001) begin tests_failed++; $display("[TB] FAIL quit_to_idle: got %b want %b", obs, 6'b000001); end
  endtask

  task automatic test_step_count();
    stall = 1'b1;
    issue(2'b10, 32'd3);
    tests_run++;
    if (obs !== 6'b101001) begin tests_failed++; $display("[TB] FAIL step3_start: got %b want %b", obs, 6'b101001); end
    tick();
    // Non-stalled cycles alternate: 0 (count), 1, 0 (count), 1, then the final count.
    for (int i = 0; i < 4; i++) begin
      stall = (i % 2) == 1;
      tick();
      tests_run++;
      if (obs !== 6'b001001) begin tests_failed++; $display("[TB] FAIL step3_counting[%0d]: got %b want %b", i, obs, 6'b001001); end
    end
    stall = 1'b0;
    tick();
    stall = 1'b1;
    tests_run++;
    if (obs !== 6'b010010) begin tests_failed++; $display("[TB] FAIL step3_done: got %b want %b", obs, 6'b010010); end
    tick();
    tests_run++;
    if (obs !== 6'b000001) begin tests_failed++; $display("[TB] FAIL step3_idle: got %b want %b", obs, 6'b000001); end
  endtask

  task automatic test_breakpoint();
    issue(2'b11, 32'h100);
    issue(2'b00, 32'h0);
    tests_run++;
    if (obs !== 6'b101001) begin tests_failed++; $display("[TB] FAIL brk_run_start: got %b want %b", obs, 6'b101001); end
    stall = 1'b0;
    pc_if = 32'hF8; tick();
    tests_run++;
    if (obs !== 6'b001001) begin tests_failed++; $display("[TB] FAIL brk_pc_f8: got %b want %b", obs, 6'b001001); end
    pc_if = 32'hFC; tick();
    tests_run++;
    if (obs !== 6'b001001) begin tests_failed++; $display("[TB] FAIL brk_pc_fc: got %b want %b", obs, 6'b001001); end
    pc_if = 32'h100; tick();
    pc_if = 32'h0;
    tests_run++;
    if (obs !== 6'b010100) begin tests_failed++; $display("[TB] FAIL brk_stop: got %b want %b", obs, 6'b010100); end
    tick();
    tests_run++;
    if (obs !== 6'b000101) begin tests_failed++; $display("[TB] FAIL brk_sticky: got %b want %b", obs, 6'b000101); end
    issue(2'b00, 32'h0);
    tests_run++;
    if (obs !== 6'b101001) begin tests_failed++; $display("[TB] FAIL brk_cleared_by_run: got %b want %b", obs, 6'b101001); end
    issue(2'b01, 32'h0);
    tick();
  endtask

  task automatic test_simultaneous();
    stall = 1'b1;
    issue(2'b10, 32'd2);
    tests_run++;
    if (obs !== 6'b101001) begin tests_failed++; $display("[TB] FAIL sim_step_start: got %b want %b", obs, 6'b101001); end
    tick();
    stall = 1'b0; pc_if = 32'h40;
    tick();
    tests_run++;
    if (obs !== 6'b001001) begin tests_failed++; $display("[TB] FAIL sim_first_count: got %b want %b", obs, 6'b001001); end
    pc_if = 32'h100;
    issue(2'b01, 32'h0);
    pc_if = 32'h0; stall = 1'b1;
    tests_run++;
    if (obs !== 6'b010110) begin tests_failed++; $display("[TB] FAIL sim_stop: got %b want %b", obs, 6'b010110); end
    tick();
    tests_run++;
    if (obs !== 6'b000101) begin tests_failed++; $display("[TB] FAIL sim_single_pulse: got %b want %b", obs, 6'b000101); end
  endtask

  task automatic test_step_zero_brk_clear();
    issue(2'b10, 32'd0);
    tests_run++;
    if (obs !== 6'b000111) begin tests_failed++; $display("[TB] FAIL step0_done: got %b want %b", obs, 6'b000111); end
    tick();
    tests_run++;
    if (obs !== 6'b000101) begin tests_failed++; $display("[TB] FAIL step0_pulse_once: got %b want %b", obs, 6'b000101); end
    issue(2'b11, 32'hFFFF_FFFF);
    issue(2'b00, 32'h0);
    stall = 1'b0; pc_if = 32'h100;
    tick();
    tests_run++;
    if (obs !== 6'b001001) begin tests_failed++; $display("[TB] FAIL brk_disabled: got %b want %b", obs, 6'b001001); end
    issue(2'b11, 32'h100);
    tests_run++;
    if (obs !== 6'b001001) begin tests_failed++; $display("[TB] FAIL brk_set_uses_old: got %b want %b", obs, 6'b001001); end
    tick();
    tests_run++;
    if (obs !== 6'b010100) begin tests_failed++; $display("[TB] FAIL brk_set_then_hit: got %b want %b", obs, 6'b010100); end
    pc_if = 32'h0; stall = 1'b1;
    tick();
    issue(2'b11, 32'hFFFF_FFFF);
  endtask

  task automatic test_reset_mid_step();
    stall = 1'b1;
    issue(2'b10, 32'd5);
    tests_run++;
    if (obs !== 6'b101001) begin tests_failed++; $display("[TB] FAIL rst_step_start: got %b want %b", obs, 6'b101001); end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (obs !== 6'b000001) begin tests_failed++; $display("[TB] FAIL rst_async_clear: got %b want %b", obs, 6'b000001); end
    tick();
    rst = 1'b0;
    tick();
    issue(2'b00, 32'h0);
    tests_run++;
    if (obs !== 6'b101001) begin tests_failed++; $display("[TB] FAIL rst_run_again: got %b want %b", obs, 6'b101001); end
    tick();
    tests_run++;
    if (obs !== 6'b001001) begin tests_failed++; $display("[TB] FAIL rst_running: got %b want %b", obs, 6'b001001); end
    issue(2'b01, 32'h0);
    tests_run++;
    if (obs !== 6'b010000) begin tests_failed++; $display("[TB] FAIL rst_final_quit: got %b want %b", obs, 6'b010000); end
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_run_quit();
    test_step_count();
    test_breakpoint();
    test_simultaneous();
    test_step_zero_brk_clear();
    test_reset_mid_step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run-control sequencer that drives the CPU status block's `cpu_start` and `quit_cmd` inputs. It accepts host run-control commands (RUN, QUIT, STEP n, SET_BRK) over a valid/ready handshake. It issues the start and quit pulses, counts non-stalled cycles for single/multi-step, and stops the core on a fetch-PC breakpoint. It sits between the host command decoder and the CPU status block, and monitors `stall` and the fetch PC.

## Interface
- PC_W, 32, width of fetch PC and breakpoint address
- STEP_W, 16, width of step counter (from `cmd_arg[STEP_W-1:0]`)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  command accepted when `cmd_valid & cmd_ready` at a rising edge
- cmd_op  in  2  00 RUN, 01 QUIT, 10 STEP, 11 SET_BRK
- cmd_arg  in  32  STEP count, or breakpoint address
- stall  in  1  pipeline stall from the status block; low means the pipeline advanced this cycle
- pc_if  in  PC_W  current fetch PC
- cpu_start  out  1  one-cycle start pulse to the status block
- quit_cmd  out  1  one-cycle quit pulse to the status block
- running  out  1  high in RUN or STEP state
- brk_hit  out  1  sticky; set when a breakpoint stopped the core
- step_done  out  1  one-cycle pulse when a STEP completes

## Operation
- States: IDLE, RUN, STEP, QUIT.
- `cmd_ready` = 1 in IDLE, RUN and STEP; 0 in QUIT.
- IDLE:
  - RUN: pulse `cpu_start`, clear `brk_hit`, go to RUN.
  - STEP with n = `cmd_arg[STEP_W-1:0]`:
    - n == 0: `step_done` pulses next cycle; stay in IDLE; no `cpu_start`.
    - n > 0: pulse `cpu_start`, load `cnt`=n, clear `brk_hit`, go to STEP.
  - QUIT: accepted, no pulse, stay in IDLE.
- SET_BRK is valid in any state that has `cmd_ready`=1.
  - `cmd_arg` all-ones: clear `brk_en`.
  - Otherwise: load `brk_addr`=`cmd_arg[PC_W-1:0]` and set `brk_en`.
- RUN and STEP:
  - RUN and STEP commands are accepted and ignored.
  - QUIT: pulse `quit_cmd`, go to QUIT.
- Breakpoint condition: `brk_en & ~stall & pc_if==brk_addr`. In RUN or STEP it pulses `quit_cmd`, sets `brk_hit` and goes to QUIT.
- STEP counting:
  - Each cycle with `~stall` decrements `cnt`.
  - When `cnt`==1 and `~stall`: pulse `quit_cmd` and `step_done`, go to QUIT.
- QUIT: hold exactly one cycle, then go to IDLE. This guarantees the status block has cleared its run state before any next `cpu_start`.
- Simultaneous events:
  - Breakpoint, step end and host QUIT in the same cycle produce exactly one `quit_cmd` pulse.
  - `brk_hit` is set if the breakpoint condition holds.
  - `step_done` pulses if the step end condition holds.
  - SET_BRK accepted in the same cycle as a compare: the compare uses the old `brk_addr`/`brk_en`.
- `cnt` does not wrap; it is only decremented in STEP with `cnt` ≥ 1.

## Timing
- All outputs are registered except `cmd_ready` (decoded from state).
- Reset values: state IDLE, `cpu_start`=0, `quit_cmd`=0, `running`=0, `brk_hit`=0, `step_done`=0, `brk_en`=0, `brk_addr`=0, `cnt`=0.
- `cmd_ready`=1 during reset release.
- Command accepted at edge T:
  - `cpu_start` or `quit_cmd` is high in cycle T+1 only.
  - State updates at edge T.
  - `running` goes high at edge T for RUN/STEP.
- The status block sees `cpu_start` in T+1 and asserts run at T+2. `stall` is therefore high in T+1, so the first counted cycle is at least T+2.
- Stop event detected in cycle S:
  - `quit_cmd` and `step_done` are high in S+1.
  - State is QUIT in S+1 and IDLE in S+2.
  - `running`=0 from S+1.
  - Earliest next accepted command is at the edge ending S+2.
- Reset asserted mid-run: all state clears immediately (asynchronously); any pulse in flight is truncated.

## Test plan
- Reset, then RUN → `cpu_start`=1 for one cycle, `running`=1. Then QUIT → `quit_cmd`=1 for one cycle, `cmd_ready`=0 for one cycle, then IDLE.
- STEP n=3 with `stall` low every other cycle after start → `quit_cmd` and `step_done` pulse in the cycle after the 3rd non-stalled cycle; `brk_hit`=0.
- SET_BRK 0x100, RUN, `pc_if` sweeps 0xF8, 0xFC, 0x100 with `stall`=0 → `quit_cmd` the cycle after 0x100, `brk_hit`=1. Next RUN clears `brk_hit`.
- STEP n=2 with breakpoint matching on the 2nd non-stalled cycle, plus host QUIT the same cycle → a single `quit_cmd` pulse, `brk_hit`=1, `step_done`=1.
- STEP n=0 → `step_done` pulse, no `cpu_start`, `running` stays 0. SET_BRK 0xFFFFFFFF → `brk_en` cleared; a PC match on the old address causes no stop.
- Assert `rst` during STEP with `cnt`=5 → all outputs 0 immediately. After release, RUN works normally.
